// File: rtl/serial_logic8_pkg.sv
// Shared definitions for the bit-serial logic engine: op codes and FSM state encodings.
package serial_logic8_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_logic8_bit_logic.sv
// Single 1-bit logic cell: every gate evaluated in parallel, op code picks one through a 4:1 mux.
module bit_logic
  import serial_logic8_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       y_o
);

  logic and_w, or_w, xor_w, nand_w;

  assign and_w  = a_i & b_i;
  assign or_w   = a_i | b_i;
  assign xor_w  = a_i ^ b_i;
  assign nand_w = ~and_w;

  always_comb begin
    y_o = and_w;
    case (op_i)
      OP_AND:  y_o = and_w;
      OP_OR:   y_o = or_w;
      OP_XOR:  y_o = xor_w;
      OP_NAND: y_o = nand_w;
      default: y_o = and_w;
    endcase
  end

endmodule

// File: rtl/serial_logic8.sv
// Bit-serial bitwise logic engine: one result bit per clock, LSB first, valid/ready on both sides.
module serial_logic8
  import serial_logic8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, out_q;
  logic [1:0]       op_q;
  logic             out_zero_q;
  logic             bit_d;
  logic [WIDTH-1:0] res_d;

  bit_logic u_cell (
    .op_i (op_q),
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .y_o  (bit_d)
  );

  assign res_d = {bit_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      op_q       <= OP_AND;
      out_q      <= '0;
      out_zero_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= inA;
            b_q     <= inB;
            op_q    <= op;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // The last bit is folded straight into the output register on the final RUN edge.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            out_q      <= res_d;
            out_zero_q <= (res_d == '0);
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_zero_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out       = out_q;
  assign out_zero  = out_zero_q;

endmodule
